// File: rtl/sb_rx_msg_queue.sv
// Receive-side sideband message queue: buffers decoded SB headers plus 64-bit payloads
// and serves them through the available/req/valid handshake used by the LTSM blocks.
package sb_rx_msg_queue_pkg;
    typedef enum logic [7:0] {
        SB_MSG_NONE              = 8'h00,
        SBINIT_OUT_OF_RESET      = 8'h01,
        SBINIT_DONE_req          = 8'h02,
        SBINIT_DONE_resp         = 8'h03,
        MBINIT_PARAM_config_req  = 8'h10,
        MBINIT_PARAM_config_resp = 8'h11,
        MBINIT_CAL_done_req      = 8'h12,
        MBINIT_CAL_done_resp     = 8'h13
    } msg_num_t;

    typedef struct packed {
        msg_num_t    msg_num;
        logic [15:0] msg_info;
    } SB_msg_t;

    function automatic SB_msg_t reset_SB_msg();
        SB_msg_t m;
        m = '0;
        return m;
    endfunction
endpackage

// Occupancy-counted circular buffer; pop output is registered (req at edge N -> valid after N).
// Full queue drops writes and sets a sticky overflow flag unless a pop frees a slot that cycle.
module sb_rx_msg_queue
    import sb_rx_msg_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_100MHz,
    input  logic                       reset,
    input  logic                       enable_i,
    input  logic                       flush_i,
    input  logic                       RX_msg_wr_i,
    input  SB_msg_t                    RX_msg_i,
    input  logic [63:0]                RX_dataBus_i,
    input  logic                       SB_RX_msg_req_i,
    output logic                       SB_RX_msg_available_o,
    output logic                       SB_RX_msg_valid_o,
    output SB_msg_t                    SB_RX_msg_o,
    output logic [63:0]                SB_RX_dataBus_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        SB_msg_t     msg;
        logic [63:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q, valid_d;
    logic            overflow_q, overflow_d;
    SB_msg_t         msg_q, msg_d;
    logic [63:0]     data_q, data_d;

    logic            pop;
    logic            wr_acc;
    logic            wr_try;

    // valid_q in the pop term stops a registered req, still high after valid, from popping twice.
    assign pop    = enable_i && SB_RX_msg_req_i && !valid_q && (count_q != '0) && !flush_i;
    assign wr_try = enable_i && RX_msg_wr_i && !flush_i;
    assign wr_acc = wr_try && ((count_q < DEPTH_C) || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        msg_d      = msg_q;
        data_d     = data_q;

        if (enable_i) begin
            valid_d = pop;
            if (wr_try && !wr_acc) begin
                overflow_d = 1'b1;
            end
            if (wr_acc) begin
                mem_d[wr_ptr_q] = '{msg: RX_msg_i, data: RX_dataBus_i};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                msg_d    = mem_q[rd_ptr_q].msg;
                data_d   = mem_q[rd_ptr_q].data;
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (wr_acc && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !wr_acc) begin
                count_d = count_q - CW'(1);
            end
            // Flush leaves overflow and the last popped message visible.
            if (flush_i) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
                valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            msg_q      <= reset_SB_msg();
            data_q     <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            msg_q      <= msg_d;
            data_q     <= data_d;
        end
    end

    assign SB_RX_msg_available_o = (count_q != '0);
    assign SB_RX_msg_valid_o     = valid_q;
    assign SB_RX_msg_o           = msg_q;
    assign SB_RX_dataBus_o       = data_q;
    assign count_o               = count_q;
    assign overflow_o            = overflow_q;
endmodule

// File: doc/sb_rx_msg_queue.md
# sb_rx_msg_queue

Receive-side sideband message queue sitting between the sideband decoder and the LTSM sub-state blocks (SBINIT, MBINIT, ...). It buffers decoded SB messages plus their 64-bit data payload in a small FIFO and serves them through the available/req/valid handshake that the LTSM blocks use. Overflow is flagged, not silently absorbed, and a flush clears stale traffic on LTSM state changes.

## Interface
Parameters:
- DEPTH, 4, number of message entries; power of two, >= 2.

Ports:
- clk_100MHz  in  1  sideband clock; one clock domain for the whole block.
- reset  in  1  asynchronous, active-low reset.
- enable_i  in  1  block enable; when low, writes, pops and flush are ignored and all state holds.
- flush_i  in  1  synchronous queue clear.
- RX_msg_wr_i  in  1  write strobe from the decoder, one message per high cycle.
- RX_msg_i  in  SB_msg_t  decoded message header.
- RX_dataBus_i  in  64  payload accompanying RX_msg_i.
- SB_RX_msg_req_i  in  1  pop request from the LTSM consumer.
- SB_RX_msg_available_o  out  1  queue non-empty.
- SB_RX_msg_valid_o  out  1  one-cycle pulse, message outputs carry a freshly popped entry.
- SB_RX_msg_o  out  SB_msg_t  popped header.
- SB_RX_dataBus_o  out  64  popped payload.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky, a write was dropped while full.

## Operation
- Storage: DEPTH entries of {SB_msg_t, 64-bit data}; write pointer, read pointer ($clog2(DEPTH) bits, natural wrap DEPTH-1 -> 0), occupancy counter 0..DEPTH.
- Write: accepted when enable_i && RX_msg_wr_i && !flush_i && (count < DEPTH || pop this cycle). Entry stored at wr_ptr, wr_ptr++.
- Write while full with no pop: dropped, contents unchanged, overflow_o <= 1.
- Pop condition: enable_i && SB_RX_msg_req_i && !SB_RX_msg_valid_o && count != 0 && !flush_i. Entry at rd_ptr registered onto SB_RX_msg_o/SB_RX_dataBus_o, SB_RX_msg_valid_o <= 1, rd_ptr++.
- The !SB_RX_msg_valid_o term is mandatory: the consumer's req is registered and stays high one cycle after valid; that cycle must not pop a second entry.
- Pop with req high and count == 0: no action, valid stays 0.
- Simultaneous accepted write and pop: both happen, count unchanged. Applies when full (entry freed and refilled same cycle) and at count 1.
- SB_RX_msg_valid_o is high exactly one cycle per pop; message/data outputs hold the last popped value afterwards.
- flush_i (with enable_i): count, pointers, valid <= 0; overrides a same-cycle write and pop; does not clear overflow_o or message outputs.
- overflow_o clears only on reset.
- SB_RX_msg_available_o = (count_o != 0), derived from the registered count.

## Timing
- Reset (async assert, sync release): pointers 0, count_o 0, SB_RX_msg_available_o 0, SB_RX_msg_valid_o 0, SB_RX_msg_o all-zero (reset_SB_msg()), SB_RX_dataBus_o 0, overflow_o 0.
- Write at edge N: count_o and available_o updated after edge N.
- Pop latency: req sampled high at edge N -> valid and data visible after edge N, for one cycle.
- Empty queue, write at edge N: earliest pop at edge N+1.
- Steady state with a registered-req consumer: one message per 3 cycles (available -> req -> valid -> req drop).
- Reset asserted mid-pop: valid drops immediately (async); queued entries are lost.

## Test plan
- Reset then idle: all outputs zero; write msg_num=MBINIT_PARAM_config_req, data 64'h1234_5678_9ABC_DEF0 -> available 1, count 1; req pulse -> one valid cycle with that header/data, count 0, available 0.
- Held req: write 2 messages, hold req high for 6 cycles -> exactly two valid pulses, never on adjacent cycles, delivered in FIFO order.
- Fill DEPTH=4, write a 5th with no req -> 5th dropped, overflow_o 1, count 4; drain -> original 4 in order; overflow_o still 1.
- Full plus simultaneous write and pop -> count stays 4, new entry delivered last; pointers wrap correctly over 10 write/pop rounds.
- flush_i with count 3 and same-cycle write and req -> count 0, no valid pulse, available 0; a following write is delivered normally.
- enable_i low with write and req active -> no change to count or outputs; async reset mid-stream -> all outputs return to reset values within the reset cycle.
